// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// alu_cmd_sequencer : queues ALU commands, issues them one at a time, returns
// result + flags with a flag-class check. Option macro: DIV_ZERO_GUARD_EN.
// Revision: 1.0
// ============================================================================
module alu_cmd_sequencer #(
    parameter int CMD_DEPTH = 4,
    parameter int ALU_LAT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    input  logic [3:0]  cmd_fun,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_fun,
    input  logic [15:0] alu_out,
    input  logic        arith_flag,
    input  logic        logic_flag,
    input  logic        cmp_flag,
    input  logic        shift_flag,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [3:0]  rsp_flags,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = $clog2(CMD_DEPTH);
    localparam int CW = $clog2(ALU_LAT + 1);
    localparam logic [3:0] FUN_NOP = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [35:0]   mem [CMD_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [CW-1:0] cnt;

    logic        full, empty, push, pop;
    logic        issue, guard, capture, release_rsp, div0;
    logic [15:0] head_a, head_b;
    logic [3:0]  head_fun;
    logic [3:0]  flags_in;

    function automatic logic [3:0] exp_flags(input logic [3:0] fun);
        if (fun <= 4'h3)      return 4'b1000;
        else if (fun <= 4'h9) return 4'b0100;
        else if (fun <= 4'hC) return 4'b0010;
        else if (fun <= 4'hE) return 4'b0001;
        else                  return 4'b0000;
    endfunction

    assign full      = (count == (AW+1)'(CMD_DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = !full && !rst;
    assign push      = cmd_valid && cmd_ready;
    assign busy      = (state != IDLE) || !empty;
    assign head_a    = mem[rd_ptr][35:20];
    assign head_b    = mem[rd_ptr][19:4];
    assign head_fun  = mem[rd_ptr][3:0];
    assign flags_in  = {arith_flag, logic_flag, cmp_flag, shift_flag};

`ifdef DIV_ZERO_GUARD_EN
    assign div0 = (head_fun == 4'b0011) && (head_b == 16'h0000);
`else
    assign div0 = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_a, cmd_b, cmd_fun};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        issue       = 1'b0;
        guard       = 1'b0;
        capture     = 1'b0;
        release_rsp = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (div0) begin
                        guard     = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        issue     = 1'b1;
                        state_nxt = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    release_rsp = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ALU operands stay frozen from issue until the response is consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_fun   <= FUN_NOP;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_flags <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (issue) begin
                alu_a   <= head_a;
                alu_b   <= head_b;
                alu_fun <= head_fun;
                cnt     <= CW'(ALU_LAT);
            end else if (state == EXEC && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (capture) begin
                rsp_data  <= alu_out;
                rsp_flags <= flags_in;
                rsp_err   <= (flags_in != exp_flags(alu_fun));
                rsp_valid <= 1'b1;
            end
            if (guard) begin
                rsp_data  <= 16'hFFFF;
                rsp_flags <= 4'b1000;
                rsp_err   <= 1'b1;
                rsp_valid <= 1'b1;
            end
            if (release_rsp) begin
                rsp_valid <= 1'b0;
                alu_fun   <= FUN_NOP;
            end
        end
    end

endmodule
`default_nettype wire
